// File: rtl/if_fetch_stage_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_stage_pkg
//   Shared definitions for the instruction-fetch stage: data/address widths,
//   FSM state encodings, the default NOP encoding, the skid-buffer entry type
//   and the modulo PC increment helper.
// ---------------------------------------------------------------------------
package if_fetch_stage_pkg;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 16;

  // Fetch FSM encodings (plain constants for legacy tool compatibility)
  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;

  localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = 16'h0800;

  // One parked instruction together with the address it was fetched from
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } skid_entry_t;

  // PC arithmetic wraps silently at the top of the 16-bit space
  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc,
                                               input logic [ADDR_W-1:0] step);
    pc_inc = pc + step;
  endfunction

endpackage

// File: rtl/if_fetch_stage_skid_buf.sv
// ---------------------------------------------------------------------------
// if_skid_buf
//   One-entry buffer that parks a returned instruction while decode is
//   stalled and the IF/ID register is already occupied.
// Ports
//   i_clk    : clock
//   i_rst    : synchronous active-high reset (empties the buffer)
//   i_clear  : discard contents (redirect); wins over load/drain
//   i_load   : write i_entry, buffer becomes full
//   i_drain  : contents consumed, buffer becomes empty
//   i_entry  : {instr, pc} to park
//   o_full   : buffer holds a valid entry
//   o_entry  : parked {instr, pc}
// ---------------------------------------------------------------------------
module if_skid_buf
  import if_fetch_stage_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clear,
  input  logic        i_load,
  input  logic        i_drain,
  input  skid_entry_t i_entry,
  output logic        o_full,
  output skid_entry_t o_entry
);

  logic        r_full;
  skid_entry_t r_entry;

  // Occupancy flag and stored entry
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_full  <= 1'b0;
      r_entry <= '0;
    end else if (i_clear) begin
      r_full  <= 1'b0;
    end else if (i_load) begin
      r_full  <= 1'b1;
      r_entry <= i_entry;
    end else if (i_drain) begin
      r_full  <= 1'b0;
    end else begin
      r_full  <= r_full;
    end
  end

  assign o_full  = r_full;
  assign o_entry = r_entry;

endmodule

// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//   Instruction-fetch stage. Owns the PC, issues req/ack fetches to
//   instruction memory and fills the IF/ID pipeline register. Handles decode
//   stalls (via a one-entry skid buffer), branch/jump redirects, shared-memory
//   conflicts and arbitrary memory latency.
// Ports
//   i_clk, i_rst        : clock, synchronous active-high reset
//   o_imem_req          : fetch request, held with stable address until ack
//   o_imem_addr         : fetch address
//   i_imem_ack          : one-cycle pulse, i_imem_rdata valid (may be same cycle)
//   i_imem_rdata        : fetched instruction
//   i_mem_conflict      : data stage owns the memory this cycle
//   i_stall             : decode cannot accept, IF/ID must hold
//   i_redirect          : taken branch/jump, discard younger fetches
//   i_redirect_pc       : redirect target
//   o_id_valid          : IF/ID holds a real instruction
//   o_id_instr          : IF/ID instruction (NOP_INSTR when invalid)
//   o_id_pc             : PC of o_id_instr
//   o_id_pc_next        : o_id_pc + PC_STEP (link value)
// ---------------------------------------------------------------------------
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] PC_STEP   = 16'd1,
  parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req,
  output logic [15:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [15:0] i_imem_rdata,
  input  logic        i_mem_conflict,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [15:0] i_redirect_pc,
  output logic        o_id_valid,
  output logic [15:0] o_id_instr,
  output logic [15:0] o_id_pc,
  output logic [15:0] o_id_pc_next
);

  logic [1:0]  r_state;
  logic [15:0] r_pc;
  logic [15:0] r_req_addr;

  logic        r_id_valid;
  logic [15:0] r_id_instr;
  logic [15:0] r_id_pc;
  logic [15:0] r_id_pc_next;

  logic        w_req_raw;
  logic        w_issue;
  logic [15:0] w_addr;
  logic        w_ack_ok;
  logic        w_capture;
  logic        w_cap_to_id;
  logic        w_skid_load;
  logic        w_skid_drain;
  logic        w_skid_full;
  skid_entry_t w_skid_in;
  skid_entry_t w_skid_out;

  // Request/address selection. The request must react to mem_conflict in the
  // same cycle, so these are combinational rather than registered.
  always_comb begin
    w_req_raw = 1'b0;
    w_addr    = r_pc;
    case (r_state)
      ST_FETCH: begin
        // New fetches wait until any parked instruction has been drained
        w_req_raw = !i_mem_conflict && !w_skid_full;
        w_addr    = r_pc;
      end
      ST_WAIT, ST_DROP: begin
        w_req_raw = !i_mem_conflict;
        w_addr    = r_req_addr;
      end
      default: begin
        w_req_raw = 1'b0;
        w_addr    = r_pc;
      end
    endcase
  end

  assign w_issue  = w_req_raw && !i_rst;
  // An ack only counts when our request is actually visible to memory
  assign w_ack_ok = w_issue && i_imem_ack;

  assign o_imem_req  = w_issue;
  assign o_imem_addr = w_addr;

  // Returned data is kept unless it belongs to a dropped or redirected fetch.
  // w_addr is used (not r_req_addr) so a same-cycle ack in FETCH tags correctly.
  assign w_capture    = w_ack_ok && (r_state != ST_DROP) && !i_redirect;
  assign w_cap_to_id  = w_capture && (!i_stall || !r_id_valid);
  assign w_skid_load  = w_capture && i_stall && r_id_valid;
  assign w_skid_drain = !i_redirect && !w_capture && !i_stall && w_skid_full;
  assign w_skid_in    = '{instr: i_imem_rdata, pc: w_addr};

  if_skid_buf u_skid (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (i_redirect),
    .i_load  (w_skid_load),
    .i_drain (w_skid_drain),
    .i_entry (w_skid_in),
    .o_full  (w_skid_full),
    .o_entry (w_skid_out)
  );

  // Fetch FSM, PC and in-flight request address
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_FETCH;
      r_pc       <= RESET_PC;
      r_req_addr <= RESET_PC;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (w_issue) begin
            r_req_addr <= r_pc;
          end else begin
            r_req_addr <= r_req_addr;
          end
          if (i_redirect) begin
            r_pc <= i_redirect_pc;
            // A request already on the bus must still be completed
            r_state <= (w_issue && !i_imem_ack) ? ST_DROP : ST_FETCH;
          end else if (w_ack_ok) begin
            r_pc    <= pc_inc(r_pc, PC_STEP);
            r_state <= ST_FETCH;
          end else if (w_issue) begin
            r_state <= ST_WAIT;
          end else begin
            r_state <= ST_FETCH;
          end
        end
        ST_WAIT: begin
          if (i_redirect) begin
            r_pc    <= i_redirect_pc;
            r_state <= w_ack_ok ? ST_FETCH : ST_DROP;
          end else if (w_ack_ok) begin
            r_pc    <= pc_inc(r_req_addr, PC_STEP);
            r_state <= ST_FETCH;
          end else begin
            r_state <= ST_WAIT;
          end
        end
        ST_DROP: begin
          // Only the target moves; the orphaned request finishes at its old address
          if (i_redirect) begin
            r_pc <= i_redirect_pc;
          end else begin
            r_pc <= r_pc;
          end
          if (w_ack_ok) begin
            r_state <= ST_FETCH;
          end else begin
            r_state <= ST_DROP;
          end
        end
        default: begin
          r_state <= ST_FETCH;
        end
      endcase
    end
  end

  // IF/ID pipeline register: redirect > capture > drain/bubble > stall hold
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_id_valid   <= 1'b0;
      r_id_instr   <= NOP_INSTR;
      r_id_pc      <= 16'h0000;
      r_id_pc_next <= 16'h0000;
    end else if (i_redirect) begin
      r_id_valid <= 1'b0;
      r_id_instr <= NOP_INSTR;
    end else if (w_cap_to_id) begin
      r_id_valid   <= 1'b1;
      r_id_instr   <= i_imem_rdata;
      r_id_pc      <= w_addr;
      r_id_pc_next <= pc_inc(w_addr, PC_STEP);
    end else if (!i_stall) begin
      if (w_skid_full) begin
        r_id_valid   <= 1'b1;
        r_id_instr   <= w_skid_out.instr;
        r_id_pc      <= w_skid_out.pc;
        r_id_pc_next <= pc_inc(w_skid_out.pc, PC_STEP);
      end else begin
        r_id_valid <= 1'b0;
        r_id_instr <= NOP_INSTR;
      end
    end else begin
      r_id_valid <= r_id_valid;
    end
  end

  assign o_id_valid   = r_id_valid;
  assign o_id_instr   = r_id_instr;
  assign o_id_pc      = r_id_pc;
  assign o_id_pc_next = r_id_pc_next;

endmodule
